// File: rtl/matrix_scan_decoder_pkg.sv
// Shared constants, types and helpers for the LED-matrix scan decoder.
package matrix_scan_decoder_pkg;

  localparam int unsigned N_ROWS = 6;
  localparam int unsigned N_COLS = 6;
  localparam int unsigned N_PIX  = N_ROWS * N_COLS;
  localparam int unsigned IDX_W  = $clog2(N_ROWS);
  localparam int unsigned CNT_W  = $clog2(N_ROWS + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DWELL = 2'd1,
    HELD  = 2'd2
  } scan_state_t;

  typedef logic [N_COLS-1:0] line_t;
  typedef logic [N_PIX-1:0]  frame_t;

  // One synchronised sample of the scan bus
  typedef struct packed {
    logic [N_ROWS-1:0] row;
    line_t             col;
  } scan_t;

  function automatic int unsigned pix_idx(input int unsigned r, input int unsigned c);
    return r * N_COLS + c;
  endfunction

endpackage

// File: rtl/matrix_scan_decoder_if.sv
// Scan inputs and rebuilt-frame outputs of the matrix scan decoder.
interface matrix_scan_decoder_if;
  import matrix_scan_decoder_pkg::*;

  logic [N_ROWS-1:0] row;
  line_t             col;
  frame_t            frame;
  logic              frame_valid;
  logic [IDX_W-1:0]  row_idx;
  logic              scan_err;
  logic              scan_idle;

  modport master (
    output row, col,
    input  frame, frame_valid, row_idx, scan_err, scan_idle
  );

  modport slave (
    input  row, col,
    output frame, frame_valid, row_idx, scan_err, scan_idle
  );

endinterface

// File: rtl/matrix_row_sync.sv
// Synchronises row/col and classifies the synchronised row as one-hot or multi-hot,
// with the index of the set bit.
module matrix_row_sync
  import matrix_scan_decoder_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_ROWS-1:0] row,
  input  line_t             col,
  output scan_t             sample,
  output logic              onehot_c,
  output logic              multi_c,
  output logic [IDX_W-1:0]  idx_c
);

  scan_t [SYNC_STAGES-1:0] pipe;
  logic  [CNT_W-1:0]       ones_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe <= '0;
    end else begin
      pipe[0] <= '{row: row, col: col};
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign sample = pipe[SYNC_STAGES-1];

  // Population count and encoder; idx is only meaningful when one-hot
  always_comb begin
    ones_c = '0;
    idx_c  = '0;
    for (int i = 0; i < int'(N_ROWS); i++) begin
      if (sample.row[i]) begin
        ones_c = ones_c + CNT_W'(1);
        idx_c  = IDX_W'(i);
      end
    end
    onehot_c = (ones_c == CNT_W'(1));
    multi_c  = (ones_c > CNT_W'(1));
  end

endmodule

// File: rtl/matrix_scan_decoder.sv
// Rebuilds 6x6 LED-matrix frames from the multiplexed row/col scan and strobes each
// completed frame; flags multi-hot rows and a stalled scan.
module matrix_scan_decoder
  import matrix_scan_decoder_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned MIN_DWELL      = 16,
  parameter int unsigned TIMEOUT        = 24000,
  parameter bit          COL_ACTIVE_LOW = 1'b1
) (
  input logic                  clk,
  input logic                  rst,
  matrix_scan_decoder_if.slave scan
);

  localparam int unsigned DWELL_W = $clog2(MIN_DWELL + 1);
  localparam int unsigned IDLE_W  = $clog2(TIMEOUT + 1);

  scan_t            sample;
  logic             onehot_c;
  logic             multi_c;
  logic [IDX_W-1:0] idx_c;

  matrix_row_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .rst      (rst),
    .row      (scan.row),
    .col      (scan.col),
    .sample   (sample),
    .onehot_c (onehot_c),
    .multi_c  (multi_c),
    .idx_c    (idx_c)
  );

  scan_state_t         state_q, state_d;
  logic [DWELL_W-1:0]  dwell_q, dwell_d;
  logic [IDX_W-1:0]    row_idx_q, row_idx_d;
  line_t [N_ROWS-1:0]  lines_q, lines_d;
  logic [N_ROWS-1:0]   mask_q, mask_d;
  logic [IDLE_W-1:0]   idle_q, idle_d;
  frame_t              frame_q, frame_d;
  logic                frame_valid_q, frame_valid_d;
  logic                scan_err_q;
  logic                scan_idle_q;
  logic                capture_c;
  logic                same_row_c;
  line_t               pix_c;

  assign pix_c      = sample.col ^ {N_COLS{COL_ACTIVE_LOW}};
  assign same_row_c = onehot_c && (idx_c == row_idx_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      dwell_q       <= '0;
      row_idx_q     <= '0;
      lines_q       <= '0;
      mask_q        <= '0;
      idle_q        <= '0;
      frame_q       <= '0;
      frame_valid_q <= 1'b0;
      scan_err_q    <= 1'b0;
      scan_idle_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      dwell_q       <= dwell_d;
      row_idx_q     <= row_idx_d;
      lines_q       <= lines_d;
      mask_q        <= mask_d;
      idle_q        <= idle_d;
      frame_q       <= frame_d;
      frame_valid_q <= frame_valid_d;
      scan_err_q    <= scan_err_q | multi_c;
      scan_idle_q   <= (idle_d == IDLE_W'(TIMEOUT));
    end
  end

  // Dwell FSM: a row is captured once it has been stable for MIN_DWELL samples
  always_comb begin
    state_d   = state_q;
    dwell_d   = dwell_q;
    row_idx_d = row_idx_q;
    capture_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (onehot_c) begin
          state_d   = DWELL;
          dwell_d   = DWELL_W'(1);
          row_idx_d = idx_c;
        end
      end
      DWELL: begin
        if (same_row_c) begin
          if (dwell_q < DWELL_W'(MIN_DWELL)) dwell_d = dwell_q + DWELL_W'(1);
          if (dwell_q >= DWELL_W'(MIN_DWELL - 1)) begin
            capture_c = 1'b1;
            state_d   = HELD;
          end
        end else if (onehot_c) begin
          dwell_d   = DWELL_W'(1);
          row_idx_d = idx_c;
        end else begin
          state_d = IDLE;
          dwell_d = '0;
        end
      end
      HELD: begin
        if (same_row_c) begin
          state_d = HELD;
        end else if (onehot_c) begin
          state_d   = DWELL;
          dwell_d   = DWELL_W'(1);
          row_idx_d = idx_c;
        end else begin
          state_d = IDLE;
          dwell_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        dwell_d = '0;
      end
    endcase
  end

  // Line buffer and frame assembly; the completing line is folded into the frame directly
  always_comb begin
    lines_d       = lines_q;
    mask_d        = mask_q;
    frame_d       = frame_q;
    frame_valid_d = 1'b0;
    if (capture_c) begin
      lines_d[row_idx_q] = pix_c;
      mask_d[row_idx_q]  = 1'b1;
      if (&mask_d) begin
        for (int r = 0; r < int'(N_ROWS); r++) begin
          for (int c = 0; c < int'(N_COLS); c++) begin
            frame_d[pix_idx(r, c)] = lines_d[r][c];
          end
        end
        frame_valid_d = 1'b1;
        mask_d        = '0;
      end
    end
  end

  // Saturating time-since-capture counter; a capture always restarts it
  always_comb begin
    if (capture_c) begin
      idle_d = '0;
    end else if (idle_q == IDLE_W'(TIMEOUT)) begin
      idle_d = idle_q;
    end else begin
      idle_d = idle_q + IDLE_W'(1);
    end
  end

  assign scan.frame       = frame_q;
  assign scan.frame_valid = frame_valid_q;
  assign scan.row_idx     = row_idx_q;
  assign scan.scan_err    = scan_err_q;
  assign scan.scan_idle   = scan_idle_q;

endmodule

// File: tb/tb_matrix_scan_decoder.sv
// Directed self-checking bench for matrix_scan_decoder.
module tb_matrix_scan_decoder;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  int   fv_count = 0;
  logic [35:0] fv_frame = '0;
  int   fv_base;

  always #5 clk = ~clk;

  matrix_scan_decoder_if sif();

  matrix_scan_decoder dut (
    .clk  (clk),
    .rst  (rst),
    .scan (sif)
  );

  // Record every frame strobe and the frame it carried
  always @(negedge clk) begin
    if (sif.frame_valid === 1'b1) begin
      fv_count = fv_count + 1;
      fv_frame = sif.frame;
    end
  end

  task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic [5:0] r, input logic [5:0] c, input int n);
    sif.row = r;
    sif.col = c;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic scan_row(input int r, input logic [5:0] c, input int n);
    logic [5:0] one;
    one = 6'b000001 << r;
    hold(one, c, n);
  endtask

  initial begin
    rst     = 1'b1;
    sif.row = '0;
    sif.col = 6'b111111;
    repeat (3) @(posedge clk);
    #1;
    check("rst_frame", 36'(sif.frame), 36'h0);
    check("rst_fv", 36'(sif.frame_valid), 36'h0);
    check("rst_row_idx", 36'(sif.row_idx), 36'h0);
    check("rst_err", 36'(sif.scan_err), 36'h0);
    check("rst_idle", 36'(sif.scan_idle), 36'h0);
    rst = 1'b0;
    hold(6'b0, 6'b111111, 2);

    // Full scan, column 0 lit in every row
    fv_base = fv_count;
    for (int r = 0; r < 6; r++) scan_row(r, 6'b111110, 20);
    hold(6'b0, 6'b111111, 5);
    check("scan1_fv_count", 36'(fv_count - fv_base), 36'd1);
    check("scan1_frame", fv_frame, 36'h041041041);
    check("scan1_frame_out", sif.frame, 36'h041041041);
    check("scan1_err", 36'(sif.scan_err), 36'h0);
    check("scan1_row_idx", 36'(sif.row_idx), 36'd5);

    // Row 3 too short: no capture until a later long dwell
    fv_base = fv_count;
    for (int r = 0; r < 3; r++) scan_row(r, 6'b111101, 20);
    scan_row(3, 6'b111110, 10);
    for (int r = 4; r < 6; r++) scan_row(r, 6'b111101, 20);
    hold(6'b0, 6'b111111, 5);
    check("short_no_fv", 36'(fv_count - fv_base), 36'd0);
    scan_row(3, 6'b111101, 20);
    hold(6'b0, 6'b111111, 5);
    check("short_late_fv", 36'(fv_count - fv_base), 36'd1);
    check("short_frame", fv_frame, 36'h082082082);

    // Multi-hot glitch mid-scan
    fv_base = fv_count;
    for (int r = 0; r < 2; r++) scan_row(r, 6'b111011, 20);
    hold(6'b000101, 6'b111011, 1);
    hold(6'b0, 6'b111011, 4);
    check("multi_err_set", 36'(sif.scan_err), 36'h1);
    for (int r = 2; r < 6; r++) scan_row(r, 6'b111011, 20);
    hold(6'b0, 6'b111111, 5);
    check("multi_fv", 36'(fv_count - fv_base), 36'd1);
    check("multi_frame", fv_frame, 36'h104104104);
    check("multi_err_sticky", 36'(sif.scan_err), 36'h1);

    // Out-of-order scan, row r lights column r
    fv_base = fv_count;
    scan_row(5, ~6'b100000, 20);
    scan_row(2, ~6'b000100, 20);
    scan_row(0, ~6'b000001, 20);
    scan_row(4, ~6'b010000, 20);
    scan_row(1, ~6'b000010, 20);
    scan_row(3, ~6'b001000, 20);
    hold(6'b0, 6'b111111, 5);
    check("order_fv", 36'(fv_count - fv_base), 36'd1);
    check("order_frame", fv_frame, 36'h810204081);

    // Idle timeout: last capture was about 7 cycles before this blanking started
    hold(6'b0, 6'b111111, 23980);
    check("idle_not_yet", 36'(sif.scan_idle), 36'h0);
    hold(6'b0, 6'b111111, 30);
    check("idle_set", 36'(sif.scan_idle), 36'h1);
    fv_base = fv_count;
    hold(6'b000001, 6'b011111, 17);
    check("idle_before_capture", 36'(sif.scan_idle), 36'h1);
    hold(6'b000001, 6'b011111, 1);
    check("idle_cleared", 36'(sif.scan_idle), 36'h0);
    check("idle_row_idx", 36'(sif.row_idx), 36'd0);
    hold(6'b000001, 6'b011111, 2);
    hold(6'b0, 6'b111111, 5);
    check("idle_no_fv", 36'(fv_count - fv_base), 36'd0);

    // Reset after rows 0..2, then rows 3..5 alone must not complete a frame
    for (int r = 1; r < 3; r++) scan_row(r, 6'b000000, 20);
    hold(6'b0, 6'b111111, 3);
    rst = 1'b1;
    hold(6'b0, 6'b111111, 2);
    check("rst2_frame", sif.frame, 36'h0);
    check("rst2_err", 36'(sif.scan_err), 36'h0);
    check("rst2_idle", 36'(sif.scan_idle), 36'h0);
    check("rst2_row_idx", 36'(sif.row_idx), 36'h0);
    check("rst2_fv", 36'(sif.frame_valid), 36'h0);
    rst = 1'b0;
    fv_base = fv_count;
    for (int r = 3; r < 6; r++) scan_row(r, 6'b000000, 20);
    hold(6'b0, 6'b111111, 5);
    check("rst2_partial_no_fv", 36'(fv_count - fv_base), 36'd0);
    check("rst2_partial_frame", sif.frame, 36'h0);
    check("rst2_partial_row_idx", 36'(sif.row_idx), 36'd5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
